// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 pixel capture path.
// Holds the capture FSM encoding, default frame geometries and RGB565 field positions.
package ov7670_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_CFG = 2'd0,
      ST_SYNC     = 2'd1,
      ST_CAPTURE  = 2'd2
   } cap_state_e;

   localparam int VGA_H_ACTIVE  = 640;
   localparam int VGA_V_ACTIVE  = 480;
   localparam int QVGA_H_ACTIVE = 320;
   localparam int QVGA_V_ACTIVE = 240;

   localparam int RGB565_R_MSB = 15;
   localparam int RGB565_R_LSB = 11;
   localparam int RGB565_G_MSB = 10;
   localparam int RGB565_G_LSB = 5;
   localparam int RGB565_B_MSB = 4;
   localparam int RGB565_B_LSB = 0;

   // The camera sends the red/upper-green byte first.
   function automatic logic [15:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
      logic [15:0] px;
      px = {hi, lo};
      return px;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for slow level signals
// crossing into the local clock domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic meta_r;
   logic sync_r;

   // Two-stage resynchronization chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= din;
         sync_r <= meta_r;
      end
   end

   assign dout = sync_r;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: locks onto a full frame after configuration, assembles
// byte pairs into pixels and generates linear frame-buffer write addresses.
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_done,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   output logic              wr_en,
   output logic [15:0]       wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              frame_start,
   output logic              frame_done,
   output logic [7:0]        frame_cnt,
   output logic              geom_err
);

   localparam int CNT_W = 16;

   cap_state_e        state_r;
   logic              cfg_s;
   logic              vsync_r, href_r, vsync_q_r, href_q_r;
   logic [7:0]        d_r, hi_r;
   logic              phase_r, first_r;
   logic [CNT_W-1:0]  x_r, y_r;
   logic [ADDR_W-1:0] addr_r;

   logic              vsync_rise_s, vsync_fall_s, href_rise_s, href_fall_s;
   logic              capture_s, byte_s, phase_s, line_close_s, in_range_s;
   logic [CNT_W-1:0]  y_end_s;

   sync_2ff u_cfg_sync (
      .clk   (clk),
      .rst_n (rst),
      .din   (cfg_done),
      .dout  (cfg_s)
   );

   // Register the camera bus once, plus a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_r   <= 1'b0;
         href_r    <= 1'b0;
         d_r       <= 8'd0;
         vsync_q_r <= 1'b0;
         href_q_r  <= 1'b0;
      end else begin
         vsync_r   <= vsync;
         href_r    <= href;
         d_r       <= d;
         vsync_q_r <= vsync_r;
         href_q_r  <= href_r;
      end
   end

   assign vsync_rise_s = vsync_r & ~vsync_q_r;
   assign vsync_fall_s = ~vsync_r & vsync_q_r;
   assign href_rise_s  = href_r & ~href_q_r;
   assign href_fall_s  = ~href_r & href_q_r;
   assign capture_s    = (state_r == ST_CAPTURE);
   assign byte_s       = capture_s & href_r & ~vsync_rise_s;
   assign phase_s      = href_rise_s ? 1'b0 : phase_r;
   // A vsync rise with href still high closes the open line before the frame ends.
   assign line_close_s = capture_s & (href_fall_s | (vsync_rise_s & href_r));
   assign y_end_s      = y_r + CNT_W'(line_close_s);
   assign in_range_s   = (x_r < CNT_W'(H_ACTIVE)) && (y_r < CNT_W'(V_ACTIVE));

   // Capture FSM, byte assembler, geometry counters and error tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_WAIT_CFG;
         hi_r        <= 8'd0;
         phase_r     <= 1'b0;
         first_r     <= 1'b0;
         x_r         <= '0;
         y_r         <= '0;
         addr_r      <= '0;
         wr_en       <= 1'b0;
         wr_data     <= 16'd0;
         wr_addr     <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_cnt   <= 8'd0;
         geom_err    <= 1'b0;
      end else begin
         wr_en       <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         if (!cfg_s) begin
            state_r <= ST_WAIT_CFG;
            phase_r <= 1'b0;
         end else begin
            case (state_r)
               ST_WAIT_CFG: state_r <= ST_SYNC;
               ST_SYNC: begin
                  if (vsync_fall_s) begin
                     state_r <= ST_CAPTURE;
                     x_r     <= '0;
                     y_r     <= '0;
                     addr_r  <= '0;
                     phase_r <= 1'b0;
                     first_r <= 1'b1;
                  end
               end
               ST_CAPTURE: begin
                  if (byte_s) begin
                     if (!phase_s) begin
                        hi_r    <= d_r;
                        phase_r <= 1'b1;
                        if (first_r) begin
                           frame_start <= 1'b1;
                           first_r     <= 1'b0;
                        end
                     end else begin
                        phase_r <= 1'b0;
                        x_r     <= x_r + CNT_W'(1);
                        if (in_range_s) begin
                           wr_en   <= 1'b1;
                           wr_data <= rgb565_pack(hi_r, d_r);
                           wr_addr <= addr_r;
                           addr_r  <= addr_r + ADDR_W'(1);
                        end else begin
                           geom_err <= 1'b1;
                        end
                     end
                  end
                  if (line_close_s) begin
                     x_r     <= '0;
                     y_r     <= y_end_s;
                     phase_r <= 1'b0;
                     if ((x_r != CNT_W'(H_ACTIVE)) || phase_s || vsync_rise_s) begin
                        geom_err <= 1'b1;
                     end
                  end
                  if (vsync_rise_s) begin
                     state_r    <= ST_SYNC;
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 8'd1;
                     if (y_end_s != CNT_W'(V_ACTIVE)) begin
                        geom_err <= 1'b1;
                     end
                  end
               end
               default: state_r <= ST_WAIT_CFG;
            endcase
         end
      end
   end

endmodule
